receptor_medida_7o1: RTL and testbench
======================================

// Module: receptor_medida_7o1
// PURPOSE
//  Serial receiver for the sonar measurement stream sent by the trena transmit path.
//  Deserialises 7O1 UART characters and parses 8-char messages "CDU,cdu#":
//    CDU = angle, ASCII digits; cdu = distance, ASCII digits.
//  Presents the last complete valid message as BCD digits plus a pronto pulse.
//  Sits on the host/monitor FPGA side of the serial link.
// PARAMETERS
//  DIV  434  clock cycles per bit (50 MHz / 115200 baud)
// PORTS
//  clock           in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-low; clears all state
//  entrada_serial  in   1  serial line, idle high, asynchronous to clock
//  angulo_centena  out  4  angle hundreds digit, BCD
//  angulo_dezena   out  4  angle tens digit, BCD
//  angulo_unidade  out  4  angle units digit, BCD
//  medida_centena  out  4  distance hundreds digit, BCD
//  medida_dezena   out  4  distance tens digit, BCD
//  medida_unidade  out  4  distance units digit, BCD
//  pronto          out  1  1-cycle pulse: a new valid message is on the outputs
//  erro_paridade   out  1  1-cycle pulse: character had bad parity or bad stop bit
//  erro_formato    out  1  1-cycle pulse: character was unexpected in the message
//  db_estado       out  4  parser state code, for debug
// BEHAVIOUR
//  Reset (reset=0): all digit outputs 0; pronto, erro_* 0; receiver IDLE; parser ANG_C.
//  Input: entrada_serial passes through a 2-FF synchroniser; the reset value of both FFs is 1.
//  Receiver FSM: IDLE -> START -> DATA -> PARIDADE -> STOP -> IDLE.
//   - IDLE->START on a 1->0 edge of the line.
//   - START: sample at DIV/2 cycles. If the line is high, treat as a glitch and return to IDLE.
//   - DATA: 7 samples spaced DIV apart, LSB first.
//   - Parity is odd: ones(data) + parity bit must be odd.
//   - STOP: the sample must be 1; a 0 is a framing error, reported on erro_paridade.
//   - char_ok pulses at the stop-bit sample cycle. A char with a parity or stop error
//     is flagged and never passed to the parser as valid.
//   - After a stop=0, the receiver waits for the line to go high before re-arming.
//   - Back-to-back frames with zero idle time are supported.
//  Parser FSM, advancing on each received char:
//    ANG_C -> ANG_D -> ANG_U -> VIRG -> MED_C -> MED_D -> MED_U -> CERQ -> ANG_C
//   - Digit states accept only 0x30..0x39; store low nibble in a shadow register.
//   - VIRG accepts only 0x2C (','). CERQ accepts only 0x23 ('#').
//   - '#' accepted in CERQ: copy all six shadow digits to the outputs together.
//     pronto=1 on the next cycle; latency = 1 clock after the stop-bit sample.
//   - Unexpected char, or a char with parity/stop error: pulse the matching erro_*
//     one cycle later, then go to DESCARTA.
//   - DESCARTA: drop chars until '#', then go to ANG_C. Outputs are left unchanged.
//   - '#' received in any state other than CERQ: erro_formato, then go to ANG_C (resync).
//   - Outputs change only on a complete valid message; no partial updates.
//   - erro_paridade and erro_formato are never asserted in the same cycle as pronto.
//  Reset mid-frame aborts both FSMs immediately; the half-received message is lost.
//  db_estado codes: ANG_C=0, ANG_D=1, ANG_U=2, VIRG=3, MED_C=4, MED_D=5, MED_U=6,
//    CERQ=7, DESCARTA=8.
// STRUCTURE
//  Shared package holds: ASCII constants (ZERO=7'h30, NOVE=7'h39, VIRGULA=7'h2C,
//    CERQUILHA=7'h23), parser state encoding, default DIV.
//  Sub-module rx_serial_7O1 = synchroniser + bit-timing counter + receiver FSM.
//    Outputs dado[6:0], char_ok, erro_char.
//  The top module holds the parser FSM, the shadow registers and the output registers.
// TESTING
//  1. Send "045,123#" at DIV=434 -> angulo 0/4/5, medida 1/2/3, exactly one pronto.
//     erro_* stay 0.
//  2. Send '4' with the parity bit flipped inside "045,123#" -> erro_paridade pulse, no pronto.
//     Then send "090,010#" -> outputs 0/9/0, 0/1/0, pronto.
//  3. Send "04X,123#090,010#" -> erro_formato once, first message dropped;
//     second message gives 0/9/0, 0/1/0.
//  4. Drive a low glitch of DIV/4 cycles on the idle line -> no char_ok, no error, state ANG_C.
//  5. Drop reset low during bit 3 of the ',' char -> all outputs 0 at once.
//     The next full message parses correctly.
//  6. Send two messages back-to-back with no idle bits -> two pronto pulses;
//     final outputs match the second message.

Source files
------------

// File: rtl/receptor_medida_7o1_pkg.sv
// Shared definitions for the sonar measurement receiver.
//   - ASCII constants recognised by the message parser
//   - parser state encoding (also exported on db_estado)
//   - serial receiver state encoding
//   - default bit period (50 MHz / 115200 baud)
package receptor_medida_7o1_pkg;

   localparam int DIV_PADRAO = 434;

   localparam logic [6:0] ZERO      = 7'h30;
   localparam logic [6:0] NOVE      = 7'h39;
   localparam logic [6:0] VIRGULA   = 7'h2C;
   localparam logic [6:0] CERQUILHA = 7'h23;

   // Encoding is visible on db_estado, so the values are fixed.
   typedef enum logic [3:0] {
      ANG_C    = 4'd0,
      ANG_D    = 4'd1,
      ANG_U    = 4'd2,
      VIRG     = 4'd3,
      MED_C    = 4'd4,
      MED_D    = 4'd5,
      MED_U    = 4'd6,
      CERQ     = 4'd7,
      DESCARTA = 4'd8
   } estado_parser_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARIDADE,
      RX_STOP,
      RX_ESPERA      // stop bit was 0: wait for the line to return high
   } estado_rx_t;

   function automatic logic eh_digito(input logic [6:0] c);
      return (c >= ZERO) && (c <= NOVE);
   endfunction

   // Position of a digit state inside the six-digit shadow/output banks:
   // 0..2 = angle hundreds/tens/units, 3..5 = distance hundreds/tens/units.
   function automatic logic [2:0] indice_digito(input estado_parser_t e);
      logic [2:0] idx;
      idx = 3'd0;
      case (e)
         ANG_C:   idx = 3'd0;
         ANG_D:   idx = 3'd1;
         ANG_U:   idx = 3'd2;
         MED_C:   idx = 3'd3;
         MED_D:   idx = 3'd4;
         MED_U:   idx = 3'd5;
         default: idx = 3'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/receptor_medida_7o1_rx_serial.sv
// rx_serial_7O1: 7 data bits, odd parity, 1 stop bit UART receiver.
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-low
//   entrada_serial in   serial line, idle high, asynchronous to clock
//   dado[6:0]      out  last correctly received character
//   char_ok        out  1-cycle pulse: a good character is on dado
//   erro_char      out  1-cycle pulse: character had bad parity or bad stop bit
// char_ok and erro_char are mutually exclusive and are raised by the stop-bit
// sample; a bad character never updates dado.
module rx_serial_7O1
   import receptor_medida_7o1_pkg::*;
#(
   parameter int DIV = DIV_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   output logic [6:0] dado,
   output logic       char_ok,
   output logic       erro_char
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] FIM_BIT  = CW'(DIV - 1);
   localparam logic [CW-1:0] FIM_MEIO = CW'(DIV / 2 - 1);

   // Two-stage synchroniser plus one delayed copy for edge detection.
   // All reset to 1 so a reset never looks like a start bit.
   logic sinc_1_reg, sinc_2_reg, linha_ant_reg;
   logic linha;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc_1_reg    <= 1'b1;
         sinc_2_reg    <= 1'b1;
         linha_ant_reg <= 1'b1;
      end else begin
         sinc_1_reg    <= entrada_serial;
         sinc_2_reg    <= sinc_1_reg;
         linha_ant_reg <= sinc_2_reg;
      end
   end

   assign linha = sinc_2_reg;

   estado_rx_t      estado_reg, estado_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      bit_reg, bit_next;
   logic [6:0]      desloc_reg, desloc_next;
   logic            par_reg, par_next;
   logic [6:0]      dado_reg, dado_next;
   logic            char_ok_reg, char_ok_next;
   logic            erro_reg, erro_next;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_reg  <= RX_IDLE;
         cnt_reg     <= '0;
         bit_reg     <= '0;
         desloc_reg  <= '0;
         par_reg     <= 1'b0;
         dado_reg    <= '0;
         char_ok_reg <= 1'b0;
         erro_reg    <= 1'b0;
      end else begin
         estado_reg  <= estado_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         desloc_reg  <= desloc_next;
         par_reg     <= par_next;
         dado_reg    <= dado_next;
         char_ok_reg <= char_ok_next;
         erro_reg    <= erro_next;
      end
   end

   always_comb begin
      estado_next  = estado_reg;
      cnt_next     = cnt_reg + 1'b1;
      bit_next     = bit_reg;
      desloc_next  = desloc_reg;
      par_next     = par_reg;
      dado_next    = dado_reg;
      char_ok_next = 1'b0;
      erro_next    = 1'b0;

      case (estado_reg)
         RX_IDLE: begin
            cnt_next = '0;
            if (linha_ant_reg && !linha)
               estado_next = RX_START;
         end

         // Re-check the start bit at its centre; a short low pulse is a glitch.
         RX_START: begin
            if (cnt_reg == FIM_MEIO) begin
               cnt_next = '0;
               bit_next = '0;
               estado_next = linha ? RX_IDLE : RX_DATA;
            end
         end

         // LSB first: shift in from the top so bit 0 ends up in position 0.
         RX_DATA: begin
            if (cnt_reg == FIM_BIT) begin
               cnt_next    = '0;
               desloc_next = {linha, desloc_reg[6:1]};
               if (bit_reg == 3'd6)
                  estado_next = RX_PARIDADE;
               else
                  bit_next = bit_reg + 3'd1;
            end
         end

         RX_PARIDADE: begin
            if (cnt_reg == FIM_BIT) begin
               cnt_next    = '0;
               par_next    = linha;
               estado_next = RX_STOP;
            end
         end

         // Odd parity: XOR of data and parity bit must be 1.
         RX_STOP: begin
            if (cnt_reg == FIM_BIT) begin
               cnt_next = '0;
               if (linha && (^{desloc_reg, par_reg})) begin
                  char_ok_next = 1'b1;
                  dado_next    = desloc_reg;
               end else begin
                  erro_next = 1'b1;
               end
               estado_next = linha ? RX_IDLE : RX_ESPERA;
            end
         end

         RX_ESPERA: begin
            cnt_next = '0;
            if (linha)
               estado_next = RX_IDLE;
         end

         default: begin
            cnt_next    = '0;
            estado_next = RX_IDLE;
         end
      endcase
   end

   assign dado      = dado_reg;
   assign char_ok   = char_ok_reg;
   assign erro_char = erro_reg;

endmodule

// File: rtl/receptor_medida_7o1.sv
// receptor_medida_7o1: receives "CDU,cdu#" sonar messages over a 7O1 serial
// link and presents the last complete valid message as BCD digits.
//   clock                              in   system clock, rising edge
//   reset                              in   asynchronous, active-low
//   entrada_serial                     in   serial line, idle high
//   angulo_centena/dezena/unidade      out  angle digits, BCD
//   medida_centena/dezena/unidade      out  distance digits, BCD
//   pronto                             out  1-cycle pulse: new message on outputs
//   erro_paridade                      out  1-cycle pulse: parity/stop error
//   erro_formato                       out  1-cycle pulse: unexpected character
//   db_estado                          out  parser state code
// Digits are collected in a shadow bank and copied to the outputs in one
// step when the closing '#' arrives, so the outputs never show a partial
// message.
module receptor_medida_7o1
   import receptor_medida_7o1_pkg::*;
#(
   parameter int DIV = DIV_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   output logic [3:0] angulo_centena,
   output logic [3:0] angulo_dezena,
   output logic [3:0] angulo_unidade,
   output logic [3:0] medida_centena,
   output logic [3:0] medida_dezena,
   output logic [3:0] medida_unidade,
   output logic       pronto,
   output logic       erro_paridade,
   output logic       erro_formato,
   output logic [3:0] db_estado
);

   logic [6:0] dado;
   logic       char_ok;
   logic       erro_char;

   rx_serial_7O1 #(
      .DIV(DIV)
   ) u_rx (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .dado           (dado),
      .char_ok        (char_ok),
      .erro_char      (erro_char)
   );

   estado_parser_t estado_reg, estado_next;
   logic           pronto_reg, pronto_next;
   logic           erro_par_reg, erro_par_next;
   logic           erro_fmt_reg, erro_fmt_next;
   logic           grava;       // store dado[3:0] into the shadow digit of this state
   logic           publica;     // copy the shadow bank to the outputs
   logic [2:0]     idx_grava;

   logic [3:0] sombra_reg [6];
   logic [3:0] saida_reg  [6];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_reg   <= ANG_C;
         pronto_reg   <= 1'b0;
         erro_par_reg <= 1'b0;
         erro_fmt_reg <= 1'b0;
      end else begin
         estado_reg   <= estado_next;
         pronto_reg   <= pronto_next;
         erro_par_reg <= erro_par_next;
         erro_fmt_reg <= erro_fmt_next;
      end
   end

   always_comb begin
      estado_next   = estado_reg;
      pronto_next   = 1'b0;
      erro_par_next = 1'b0;
      erro_fmt_next = 1'b0;
      grava         = 1'b0;
      publica       = 1'b0;
      idx_grava     = indice_digito(estado_reg);

      if (erro_char) begin
         // A damaged character always aborts the message, even while discarding.
         erro_par_next = 1'b1;
         estado_next   = DESCARTA;
      end else if (char_ok) begin
         case (estado_reg)
            ANG_C, ANG_D, ANG_U, MED_C, MED_D, MED_U: begin
               if (dado == CERQUILHA) begin
                  erro_fmt_next = 1'b1;
                  estado_next   = ANG_C;
               end else if (eh_digito(dado)) begin
                  grava       = 1'b1;
                  // Digit states are consecutive codes, MED_U+1 is CERQ.
                  estado_next = estado_parser_t'(estado_reg + 4'd1);
               end else begin
                  erro_fmt_next = 1'b1;
                  estado_next   = DESCARTA;
               end
            end

            VIRG: begin
               if (dado == VIRGULA) begin
                  estado_next = MED_C;
               end else if (dado == CERQUILHA) begin
                  erro_fmt_next = 1'b1;
                  estado_next   = ANG_C;
               end else begin
                  erro_fmt_next = 1'b1;
                  estado_next   = DESCARTA;
               end
            end

            CERQ: begin
               if (dado == CERQUILHA) begin
                  publica     = 1'b1;
                  pronto_next = 1'b1;
                  estado_next = ANG_C;
               end else begin
                  erro_fmt_next = 1'b1;
                  estado_next   = DESCARTA;
               end
            end

            // Silent resync: the '#' that ends a discarded message is expected.
            DESCARTA: begin
               if (dado == CERQUILHA)
                  estado_next = ANG_C;
            end

            default: estado_next = ANG_C;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_digito
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sombra_reg[gi] <= 4'd0;
               saida_reg[gi]  <= 4'd0;
            end else begin
               if (grava && (idx_grava == 3'(gi)))
                  sombra_reg[gi] <= dado[3:0];
               if (publica)
                  saida_reg[gi] <= sombra_reg[gi];
            end
         end
      end
   endgenerate

   assign angulo_centena = saida_reg[0];
   assign angulo_dezena  = saida_reg[1];
   assign angulo_unidade = saida_reg[2];
   assign medida_centena = saida_reg[3];
   assign medida_dezena  = saida_reg[4];
   assign medida_unidade = saida_reg[5];
   assign pronto         = pronto_reg;
   assign erro_paridade  = erro_par_reg;
   assign erro_formato   = erro_fmt_reg;
   assign db_estado      = estado_reg;

endmodule

// File: tb/tb_receptor_medida_7o1.sv
// Scoreboard bench for receptor_medida_7o1. Stimulus pushes the expected
// six-digit message when it sends a valid one; the monitor pops and compares
// on every pronto pulse and counts error pulses. A short bit period keeps
// the run small.
module tb_receptor_medida_7o1;

   localparam int DIV = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       entrada_serial = 1'b1;
   logic [3:0] angulo_centena, angulo_dezena, angulo_unidade;
   logic [3:0] medida_centena, medida_dezena, medida_unidade;
   logic       pronto, erro_paridade, erro_formato;
   logic [3:0] db_estado;

   receptor_medida_7o1 #(.DIV(DIV)) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .angulo_centena (angulo_centena),
      .angulo_dezena  (angulo_dezena),
      .angulo_unidade (angulo_unidade),
      .medida_centena (medida_centena),
      .medida_dezena  (medida_dezena),
      .medida_unidade (medida_unidade),
      .pronto         (pronto),
      .erro_paridade  (erro_paridade),
      .erro_formato   (erro_formato),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   int testes = 0;
   int falhas = 0;
   int n_pronto = 0, n_par = 0, n_fmt = 0;
   logic [23:0] fila [$];

   function automatic logic [23:0] digitos();
      return {angulo_centena, angulo_dezena, angulo_unidade,
              medida_centena, medida_dezena, medida_unidade};
   endfunction

   // Monitor: compare each published message against the scoreboard.
   always @(negedge clock) begin
      if (reset) begin
         if (pronto) begin
            logic [23:0] esp;
            n_pronto++;
            testes++;
            if (fila.size() == 0) begin
               falhas++;
               $display("FAIL pronto_inesperado: got %h required no message", digitos());
            end else begin
               esp = fila.pop_front();
               if (digitos() !== esp) begin
                  falhas++;
                  $display("FAIL mensagem: got %h required %h", digitos(), esp);
               end else begin
                  $display("[TB] pronto: message %h", digitos());
               end
            end
            if (erro_paridade || erro_formato) begin
               falhas++;
               $display("FAIL pronto_com_erro: got par=%b fmt=%b required 0 0",
                        erro_paridade, erro_formato);
            end
         end
         if (erro_paridade) begin
            n_par++;
            $display("[TB] erro_paridade pulse");
         end
         if (erro_formato) begin
            n_fmt++;
            $display("[TB] erro_formato pulse");
         end
      end
   end

   task automatic verifica(input string nome, input int atual, input int esperado);
      testes++;
      if (atual != esperado) begin
         falhas++;
         $display("FAIL %s: got %0d required %0d", nome, atual, esperado);
      end
   endtask

   task automatic espera(input int n);
      entrada_serial = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic envia_char(input logic [6:0] c, input bit inverte_par);
      logic p;
      p = ~(^c) ^ inverte_par;
      entrada_serial = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 7; i++) begin
         entrada_serial = c[i];
         repeat (DIV) @(negedge clock);
      end
      entrada_serial = p;
      repeat (DIV) @(negedge clock);
      entrada_serial = 1'b1;
      repeat (DIV) @(negedge clock);
   endtask

   task automatic envia_msg(input string s);
      byte b;
      for (int i = 0; i < s.len(); i++) begin
         b = s.getc(i);
         envia_char(b[6:0], 1'b0);
      end
   endtask

   task automatic confere_contagens(input string nome, input int bp, input int bpar,
                                    input int bfmt, input int ep, input int epar,
                                    input int efmt);
      verifica({nome, "_pronto"}, n_pronto - bp, ep);
      verifica({nome, "_erro_paridade"}, n_par - bpar, epar);
      verifica({nome, "_erro_formato"}, n_fmt - bfmt, efmt);
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge clock);
      falhas++;
      $display("FAIL watchdog: got timeout required completion");
      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $fatal(1, "timeout");
   end

   initial begin : estimulo
      int bp, bpar, bfmt;
      byte b;
      string s;

      // Reset state
      repeat (5) @(negedge clock);
      verifica("reset_digitos", int'(digitos()), 0);
      verifica("reset_estado", int'(db_estado), 0);
      verifica("reset_pulsos", int'({pronto, erro_paridade, erro_formato}), 0);
      reset = 1'b1;
      espera(2 * DIV);

      // 1: simple valid message; parser sits in CERQ before the '#'
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      fila.push_back(24'h045123);
      envia_msg("045,123");
      verifica("t1_estado_cerq", int'(db_estado), 7);
      envia_msg("#");
      espera(2 * DIV);
      confere_contagens("t1", bp, bpar, bfmt, 1, 0, 0);
      verifica("t1_saida", int'(digitos()), 24'h045123);
      $display("[TB] test 1 done");

      // 2: parity error on '4' drops the message, next one is accepted
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      envia_char(7'h30, 1'b0);
      envia_char(7'h34, 1'b1);
      verifica("t2_estado_descarta", int'(db_estado), 8);
      envia_msg("5,123#");
      verifica("t2_saida_mantida", int'(digitos()), 24'h045123);
      fila.push_back(24'h090010);
      envia_msg("090,010#");
      espera(2 * DIV);
      confere_contagens("t2", bp, bpar, bfmt, 1, 1, 0);
      $display("[TB] test 2 done");

      // 3: bad character in the angle field
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      envia_msg("04X");
      verifica("t3_estado_descarta", int'(db_estado), 8);
      envia_msg(",123#");
      fila.push_back(24'h090010);
      envia_msg("090,010#");
      espera(2 * DIV);
      confere_contagens("t3", bp, bpar, bfmt, 1, 0, 1);
      verifica("t3_saida", int'(digitos()), 24'h090010);
      $display("[TB] test 3 done");

      // 4: short low glitch on the idle line is ignored
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      entrada_serial = 1'b0;
      repeat (DIV / 4) @(negedge clock);
      espera(3 * DIV);
      confere_contagens("t4", bp, bpar, bfmt, 0, 0, 0);
      verifica("t4_estado", int'(db_estado), 0);
      $display("[TB] test 4 done");

      // 5: reset during bit 3 of ','
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      envia_msg("045");
      s = ",";
      b = s.getc(0);
      entrada_serial = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         entrada_serial = b[i];
         repeat (DIV) @(negedge clock);
      end
      entrada_serial = b[3];
      repeat (DIV / 2) @(negedge clock);
      reset = 1'b0;
      #1;
      verifica("t5_reset_digitos", int'(digitos()), 0);
      verifica("t5_reset_estado", int'(db_estado), 0);
      entrada_serial = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      espera(2 * DIV);
      fila.push_back(24'h200150);
      envia_msg("200,150#");
      espera(2 * DIV);
      confere_contagens("t5", bp, bpar, bfmt, 1, 0, 0);
      $display("[TB] test 5 done");

      // 6: two messages with no idle time between frames
      bp = n_pronto; bpar = n_par; bfmt = n_fmt;
      fila.push_back(24'h123456);
      fila.push_back(24'h789012);
      envia_msg("123,456#789,012#");
      espera(2 * DIV);
      confere_contagens("t6", bp, bpar, bfmt, 2, 0, 0);
      verifica("t6_saida", int'(digitos()), 24'h789012);
      verifica("fila_vazia", fila.size(), 0);
      $display("[TB] test 6 done");

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
